// File: rtl/gpu_rasterizer.sv
// gpu_rasterizer: pops rectangle ops from the GPU op FIFO and writes them into
// the 1-bpp back framebuffer at one pixel per cycle, either as a solid fill or
// as a 1-bit asset-memory sprite scaled by a power of two.

package gpu_rasterizer_pkg;
  localparam int GPU_ASSET_ADDR_WIDTH = 12;

  typedef struct packed {
    logic [10:0]                     x;
    logic [10:0]                     y;
    logic [10:0]                     width;
    logic [10:0]                     height;
    logic                            color;
    logic                            mem_en;
    logic [GPU_ASSET_ADDR_WIDTH-1:0] mem_addr;
    logic [1:0]                      scale;
  } gpu_op_t;
endpackage

module gpu_rasterizer
  import gpu_rasterizer_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int ASSET_ADDR_WIDTH  = GPU_ASSET_ADDR_WIDTH,
  parameter int FB_ADDR_WIDTH     = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ce,
  input  gpu_op_t                     op,
  input  logic                        op_empty,
  output logic                        op_rd_en,
  output logic [ASSET_ADDR_WIDTH-1:0] asset_addr,
  input  logic                        asset_data,
  output logic                        fb_wr_en,
  output logic [FB_ADDR_WIDTH-1:0]    fb_addr,
  output logic                        fb_data,
  output logic                        idle
);

  // state   | meaning
  // S_IDLE  | waiting for an op; pops when the FIFO is non-empty
  // S_LOAD  | FIFO data valid; latch op and initialise the walk
  // S_DRAW  | issue one pixel per cycle (asset read + address compute)
  // S_FLUSH | last pixel's write goes out; may pop the next op
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_FLUSH} state_t;

  localparam logic [11:0]              HOR_LIM  = 12'(HOR_ACTIVE_PIXELS);
  localparam logic [11:0]              VER_LIM  = 12'(VER_ACTIVE_PIXELS);
  localparam logic [FB_ADDR_WIDTH-1:0] ROW_STEP = FB_ADDR_WIDTH'(HOR_ACTIVE_PIXELS);

  state_t                      state_q, state_d;
  logic [10:0]                 x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [10:0]                 col_q, col_d, row_q, row_d;
  logic                        color_q, color_d, mem_en_q, mem_en_d;
  logic [1:0]                  scale_q, scale_d;
  logic [ASSET_ADDR_WIDTH-1:0] row_base_q, row_base_d, stride_q, stride_d;
  logic [FB_ADDR_WIDTH-1:0]    row_start_q, row_start_d, fb_addr_q, fb_addr_d;
  logic                        fb_wr_en_q, fb_wr_en_d;
  logic [11:0]                 px, py;
  logic [2:0]                  blk_mask;
  logic                        last_col, last_pix, pop;

  assign px       = {1'b0, x_q} + {1'b0, col_q};
  assign py       = {1'b0, y_q} + {1'b0, row_q};
  assign blk_mask = 3'((4'd1 << scale_q) - 4'd1);
  assign last_col = (col_q == w_q - 11'd1);
  assign last_pix = last_col && (row_q == h_q - 11'd1);
  // A pop is allowed from IDLE and from FLUSH so consecutive ops run without a bubble.
  assign pop      = ((state_q == S_IDLE) || (state_q == S_FLUSH)) && !op_empty;

  assign op_rd_en   = pop && !rst;
  assign asset_addr = row_base_q + ASSET_ADDR_WIDTH'(col_q >> scale_q);
  assign fb_wr_en   = fb_wr_en_q;
  assign fb_addr    = fb_addr_q;
  // The asset ROM answers one cycle after asset_addr, i.e. in the write stage.
  assign fb_data    = mem_en_q ? asset_data : color_q;
  assign idle       = (state_q == S_IDLE) && op_empty;

  // Next-state logic for the op sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_LOAD;
      S_LOAD:  state_d = ((op.width == 11'd0) || (op.height == 11'd0)) ? S_IDLE : S_DRAW;
      S_DRAW:  if (last_pix) state_d = S_FLUSH;
      S_FLUSH: state_d = pop ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: op latch, pixel walk, asset row base and write stage.
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    w_d         = w_q;
    h_d         = h_q;
    color_d     = color_q;
    mem_en_d    = mem_en_q;
    scale_d     = scale_q;
    col_d       = col_q;
    row_d       = row_q;
    row_base_d  = row_base_q;
    stride_d    = stride_q;
    row_start_d = row_start_q;
    fb_addr_d   = fb_addr_q;
    fb_wr_en_d  = 1'b0;
    case (state_q)
      S_LOAD: begin
        x_d         = op.x;
        y_d         = op.y;
        w_d         = op.width;
        h_d         = op.height;
        color_d     = op.color;
        mem_en_d    = op.mem_en;
        scale_d     = op.scale;
        col_d       = 11'd0;
        row_d       = 11'd0;
        row_base_d  = ASSET_ADDR_WIDTH'(op.mem_addr);
        stride_d    = ASSET_ADDR_WIDTH'(op.width >> op.scale);
        // One constant multiply per op; rows after this step by adding ROW_STEP.
        row_start_d = FB_ADDR_WIDTH'(op.y) * ROW_STEP;
      end
      S_DRAW: begin
        fb_wr_en_d = (px < HOR_LIM) && (py < VER_LIM);
        fb_addr_d  = row_start_q + FB_ADDR_WIDTH'(px);
        if (last_col) begin
          col_d       = 11'd0;
          row_d       = row_q + 11'd1;
          row_start_d = row_start_q + ROW_STEP;
          // Advance to the next asset row once every 2^scale screen rows.
          if ((row_q[2:0] & blk_mask) == blk_mask) row_base_d = row_base_q + stride_q;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; everything holds while ce is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      scale_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
      stride_q    <= '0;
      row_start_q <= '0;
      fb_addr_q   <= '0;
      fb_wr_en_q  <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      mem_en_q    <= mem_en_d;
      scale_q     <= scale_d;
      col_q       <= col_d;
      row_q       <= row_d;
      row_base_q  <= row_base_d;
      stride_q    <= stride_d;
      row_start_q <= row_start_d;
      fb_addr_q   <= fb_addr_d;
      fb_wr_en_q  <= fb_wr_en_d;
    end
  end

endmodule

// File: tb/tb_gpu_rasterizer.sv
// tb_gpu_rasterizer: scoreboard bench; a reference walk of each op pushes the
// expected framebuffer writes, and every observed write pops and compares.
module tb_gpu_rasterizer;
  import gpu_rasterizer_pkg::*;

  localparam int HOR = 640;
  localparam int VER = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  gpu_op_t     op = '0;
  logic        op_empty = 1'b1;
  logic        op_rd_en;
  logic [11:0] asset_addr;
  logic        asset_data = 1'b0;
  logic        fb_wr_en;
  logic [18:0] fb_addr;
  logic        fb_data;
  logic        idle;

  gpu_rasterizer dut (
    .clk(clk), .rst(rst), .ce(ce), .op(op), .op_empty(op_empty),
    .op_rd_en(op_rd_en), .asset_addr(asset_addr), .asset_data(asset_data),
    .fb_wr_en(fb_wr_en), .fb_addr(fb_addr), .fb_data(fb_data), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit data; } wr_t;

  wr_t     exp_q[$];
  gpu_op_t fifo_q[$];
  bit      asset_mem [4096];
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;
  int      pop_cyc[$];
  int      first_wr_cyc = -1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // FIFO (registered read data) and asset ROM models, gated by ce.
  always @(posedge clk) begin
    if (ce) begin
      cyc <= cyc + 1;
      asset_data <= asset_mem[asset_addr];
      if (op_rd_en && fifo_q.size() > 0) op <= fifo_q.pop_front();
    end
    op_empty <= (fifo_q.size() == 0);
  end

  // Write monitor: each accepted write pops the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (ce) begin
      if (op_rd_en) pop_cyc.push_back(cyc);
      if (fb_wr_en) begin
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        check_eq("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("fb_addr", fb_addr, e.addr);
          check_eq("fb_data", fb_data, 32'(e.data));
        end
      end
    end
  end

  function automatic gpu_op_t mk_op(int x, int y, int w, int h, bit color, bit mem_en,
                                    int mem_addr, int scale);
    gpu_op_t o;
    o.x = 11'(x); o.y = 11'(y); o.width = 11'(w); o.height = 11'(h);
    o.color = color; o.mem_en = mem_en; o.mem_addr = 12'(mem_addr); o.scale = 2'(scale);
    return o;
  endfunction

  task automatic push_op(gpu_op_t o);
    int s, stride, px, py, a;
    s = int'(o.scale);
    stride = int'(o.width) >> s;
    for (int r = 0; r < int'(o.height); r++) begin
      for (int c = 0; c < int'(o.width); c++) begin
        px = int'(o.x) + c;
        py = int'(o.y) + r;
        if (px < HOR && py < VER) begin
          a = (int'(o.mem_addr) + (r >> s) * stride + (c >> s)) % 4096;
          exp_q.push_back('{addr: py * HOR + px, data: (o.mem_en ? asset_mem[a] : o.color)});
        end
      end
    end
    fifo_q.push_back(o);
  endtask

  task automatic wait_idle(output int c1);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (idle !== 1'b1 && n < 400);
    check_eq("idle_timeout", idle, 1);
    c1 = cyc;
  endtask

  task automatic run_one(gpu_op_t o, string tag);
    int c1, n;
    pop_cyc.delete();
    first_wr_cyc = -1;
    @(posedge clk); #1;
    push_op(o);
    @(posedge clk);
    wait_idle(c1);
    n = (o.width == 0 || o.height == 0) ? 2 : int'(o.width) * int'(o.height) + 3;
    check_eq({tag, "_pops"}, pop_cyc.size(), 1);
    if (pop_cyc.size() > 0) check_eq({tag, "_cycles"}, c1 - pop_cyc[0], n);
    check_eq({tag, "_missing"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin : stim
    int c1;
    gpu_op_t a, b;
    for (int i = 0; i < 4096; i++) asset_mem[i] = 1'($urandom_range(0, 1));

    #12;
    check_eq("rst_op_rd_en", op_rd_en, 0);
    check_eq("rst_fb_wr_en", fb_wr_en, 0);
    check_eq("rst_fb_addr", fb_addr, 0);
    check_eq("rst_fb_data", fb_data, 0);
    check_eq("rst_asset_addr", asset_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_idle", idle, 1);

    // Solid fill, with first-write latency.
    run_one(mk_op(0, 0, 4, 2, 1'b1, 1'b0, 0, 0), "fill");
    if (pop_cyc.size() > 0) check_eq("fill_first_wr", first_wr_cyc - pop_cyc[0], 3);

    // Scaled sprite.
    asset_mem[0] = 1'b1; asset_mem[1] = 1'b0; asset_mem[2] = 1'b0; asset_mem[3] = 1'b1;
    run_one(mk_op(20, 100, 4, 4, 1'b0, 1'b1, 0, 1), "sprite");

    // Clipping at the bottom-right corner.
    run_one(mk_op(638, 479, 4, 3, 1'b1, 1'b0, 0, 0), "clip");

    // Zero-size op.
    run_one(mk_op(5, 5, 0, 5, 1'b1, 1'b0, 0, 0), "zero");

    // Back-to-back ops.
    a = mk_op(10, 10, 3, 2, 1'b0, 1'b0, 0, 0);
    b = mk_op(600, 470, 5, 3, 1'b0, 1'b1, 100, 2);
    pop_cyc.delete();
    @(posedge clk); #1;
    push_op(a);
    push_op(b);
    @(posedge clk);
    wait_idle(c1);
    check_eq("b2b_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) begin
      check_eq("b2b_second_pop", pop_cyc[1] - pop_cyc[0], 3 * 2 + 2);
      check_eq("b2b_cycles", c1 - pop_cyc[0], 3 * 2 + 2 + 5 * 3 + 3);
    end
    check_eq("b2b_missing", exp_q.size(), 0);

    // Clock-enable hold mid-op.
    fork
      run_one(mk_op(100, 50, 6, 3, 1'b0, 1'b1, 37, 1), "ce_hold");
      begin
        repeat (6) @(posedge clk);
        #1 ce = 1'b0;
        repeat (5) @(posedge clk);
        #1 ce = 1'b1;
      end
    join

    // Asynchronous reset mid-draw abandons the op.
    @(posedge clk); #1;
    push_op(mk_op(0, 0, 10, 4, 1'b1, 1'b0, 0, 0));
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_fb_wr_en", fb_wr_en, 0);
    check_eq("mid_rst_op_rd_en", op_rd_en, 0);
    check_eq("mid_rst_fb_addr", fb_addr, 0);
    check_eq("mid_rst_asset_addr", asset_addr, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_idle", idle, 1);

    // Random ops, including clipping and non-power-of-two widths.
    for (int k = 0; k < 8; k++) begin
      run_one(mk_op($urandom_range(0, 660), $urandom_range(0, 500), $urandom_range(0, 9),
                    $urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4095), $urandom_range(0, 3)), "rand");
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
